mario_motion: RTL and testbench

MARIO_MOTION -- requirements
Module: mario_motion

---
 rtl/mario_motion.sv | 252 +++++++++++++++++++++++++
 tb/tb_mario_motion.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mario_motion.sv
// mario_motion: per-frame motion of the player sprite.
//
// A rising edge of the vsync-rate frame_clk is synchronised into Clk.
// On the cycle after each detected edge, Mario's horizontal position,
// the camera scroll, the vertical physics state machine and the
// animation/alive outputs update once. The outputs change three Clk
// edges after frame_clk rises.
//
// Build option:
//   MARIO_VAR_JUMP_EN - releasing the jump key while still rising fast
//                       clips the upward speed to -4 (variable jump height).
//
// Ports:
//   Clk             in   1  single clock
//   Reset           in   1  asynchronous, active-low reset
//   frame_clk       in   1  vsync-rate level, asynchronous to Clk
//   keycode         in  16  two HID key slots, [15:8] and [7:0]
//   kill            in   1  death pulse, latched until the next frame
//   supported       in   1  feet rest on a platform top
//   land_req        in   1  feet entered a platform top this frame
//   land_y          in  16  top Y to snap to when landing on a platform
//   MarioX          out 16  world X
//   MarioY          out 16  screen/world Y
//   screen_offset   out 16  camera world X
//   Mario_Animation out  4  sprite selector
//   MarioAlive      out  8  1 = alive, 0 = dead
module mario_motion #(
    parameter int START_X   = 64,
    parameter int GND_Y     = 400,
    parameter int X_STEP    = 2,
    parameter int JUMP_V    = 12,
    parameter int GRAVITY   = 1,
    parameter int MAX_FALL  = 8,
    parameter int SCROLL_X  = 320,
    parameter int WORLD_MAX = 4000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [15:0] keycode,
    input  logic        kill,
    input  logic        supported,
    input  logic        land_req,
    input  logic [15:0] land_y,
    output logic [15:0] MarioX,
    output logic [15:0] MarioY,
    output logic [15:0] screen_offset,
    output logic [3:0]  Mario_Animation,
    output logic [7:0]  MarioAlive
);

    localparam logic [3:0] MARIO_RIGHT      = 4'd0;
    localparam logic [3:0] MARIO_RIGHT_JUMP = 4'd1;
    localparam logic [3:0] MARIO_LEFT       = 4'd2;
    localparam logic [3:0] MARIO_LEFT_JUMP  = 4'd3;

    localparam logic [7:0] KEY_LEFT  = 8'h04;
    localparam logic [7:0] KEY_RIGHT = 8'h07;
    localparam logic [7:0] KEY_JUMP  = 8'h1A;

    localparam logic signed [17:0] P_STEP    = 18'(X_STEP);
    localparam logic signed [17:0] P_WMAX    = 18'(WORLD_MAX);
    localparam logic signed [17:0] P_GND     = 18'(GND_Y);
    localparam logic        [16:0] P_SCROLL  = 17'(SCROLL_X);
    localparam logic        [15:0] P_SCROLL16 = 16'(SCROLL_X);
    localparam logic        [15:0] P_GND16   = 16'(GND_Y);
    localparam logic        [15:0] P_START16 = 16'(START_X);
    localparam logic signed [7:0]  P_JUMP_VY = 8'(-JUMP_V);
    localparam logic signed [8:0]  P_GRAV9   = 9'(GRAVITY);
    localparam logic signed [8:0]  P_MAXF9   = 9'(MAX_FALL);

    typedef enum logic [1:0] {
        S_GROUND = 2'd0,
        S_JUMP   = 2'd1,
        S_FALL   = 2'd2,
        S_DEAD   = 2'd3
    } state_t;

    // Keep X inside [camera left edge, world end].
    function automatic logic [15:0] clamp_x(input logic signed [17:0] x,
                                            input logic signed [17:0] lo);
        if (x < lo)
            return lo[15:0];
        else if (x > P_WMAX)
            return P_WMAX[15:0];
        else
            return x[15:0];
    endfunction

    // Apply gravity and saturate at the terminal fall speed.
    function automatic logic signed [7:0] apply_gravity(input logic signed [7:0] v);
        logic signed [8:0] t;
        t = {v[7], v} + P_GRAV9;
        if (t > P_MAXF9)
            return P_MAXF9[7:0];
        else
            return t[7:0];
    endfunction

    function automatic logic [3:0] anim_of(input logic airborne, input logic face_left);
        if (airborne)
            return face_left ? MARIO_LEFT_JUMP : MARIO_RIGHT_JUMP;
        else
            return face_left ? MARIO_LEFT : MARIO_RIGHT;
    endfunction

    logic               r_fs1, r_fs2, r_fs3;
    logic               r_v1, r_v2, r_armed;
    logic               r_kill;
    state_t             r_state;
    logic signed [7:0]  r_vy;
    logic               r_face_left;
    logic [15:0]        r_x, r_y, r_off;
    logic [3:0]         r_anim;
    logic [7:0]         r_alive;

    logic               w_tick;
    logic               w_left, w_right, w_jump;
    logic               w_face_left;
    logic signed [17:0] w_x_move;
    logic [15:0]        w_x_next;
    logic [15:0]        w_off_next;
    logic signed [7:0]  w_vy_eff;
    logic signed [17:0] w_y_sum;
    logic signed [7:0]  w_vy_grav;

    // r_armed blocks a false edge when frame_clk is already high as reset
    // releases: only a low level seen after the pipeline has filled arms it.
    assign w_tick = r_fs2 & ~r_fs3 & r_armed;

    assign w_left  = (keycode[15:8] == KEY_LEFT)  || (keycode[7:0] == KEY_LEFT);
    assign w_right = (keycode[15:8] == KEY_RIGHT) || (keycode[7:0] == KEY_RIGHT);
    assign w_jump  = (keycode[15:8] == KEY_JUMP)  || (keycode[7:0] == KEY_JUMP);

    always_comb begin
        w_x_move    = $signed({2'b00, r_x});
        w_face_left = r_face_left;
        if (w_left && !w_right) begin
            w_x_move    = w_x_move - P_STEP;
            w_face_left = 1'b1;
        end else if (w_right && !w_left) begin
            w_x_move    = w_x_move + P_STEP;
            w_face_left = 1'b0;
        end
        w_x_next = clamp_x(w_x_move, $signed({2'b00, r_off}));

        // Camera only ever moves right, tracking Mario once he passes SCROLL_X.
        if (({1'b0, w_x_next} - {1'b0, r_off}) > P_SCROLL)
            w_off_next = w_x_next - P_SCROLL16;
        else
            w_off_next = r_off;
    end

    always_comb begin
        w_vy_eff = r_vy;
`ifdef MARIO_VAR_JUMP_EN
        if (r_state == S_JUMP && !w_jump && r_vy < -8'sd4)
            w_vy_eff = -8'sd4;
`endif
        w_y_sum   = $signed({2'b00, r_y}) + $signed({{10{w_vy_eff[7]}}, w_vy_eff});
        w_vy_grav = apply_gravity(w_vy_eff);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_fs1       <= 1'b0;
            r_fs2       <= 1'b0;
            r_fs3       <= 1'b0;
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_armed     <= 1'b0;
            r_kill      <= 1'b0;
            r_state     <= S_GROUND;
            r_vy        <= 8'sd0;
            r_face_left <= 1'b0;
            r_x         <= P_START16;
            r_y         <= P_GND16;
            r_off       <= 16'd0;
            r_anim      <= MARIO_RIGHT;
            r_alive     <= 8'd1;
        end else begin
            r_fs1 <= frame_clk;
            r_fs2 <= r_fs1;
            r_fs3 <= r_fs2;
            r_v1  <= 1'b1;
            r_v2  <= r_v1;
            if (r_v2 && !r_fs2)
                r_armed <= 1'b1;
            if (kill)
                r_kill <= 1'b1;

            if (w_tick && r_state != S_DEAD) begin
                if (r_kill || kill) begin
                    r_state <= S_DEAD;
                    r_alive <= 8'd0;
                end else begin
                    r_x         <= w_x_next;
                    r_off       <= w_off_next;
                    r_face_left <= w_face_left;
                    case (r_state)
                        S_GROUND: begin
                            if (w_jump) begin
                                r_vy    <= P_JUMP_VY;
                                r_state <= S_JUMP;
                                r_anim  <= anim_of(1'b1, w_face_left);
                            end else if (r_y != P_GND16 && !supported) begin
                                r_vy    <= 8'sd0;
                                r_state <= S_FALL;
                                r_anim  <= anim_of(1'b1, w_face_left);
                            end else begin
                                r_anim  <= anim_of(1'b0, w_face_left);
                            end
                        end
                        S_JUMP, S_FALL: begin
                            if (w_y_sum < 18'sd0) begin
                                r_y     <= 16'd0;
                                r_vy    <= 8'sd0;
                                r_state <= S_FALL;
                                r_anim  <= anim_of(1'b1, w_face_left);
                            end else if (r_state == S_FALL && w_y_sum >= P_GND) begin
                                r_y     <= P_GND16;
                                r_vy    <= 8'sd0;
                                r_state <= S_GROUND;
                                r_anim  <= anim_of(1'b0, w_face_left);
                            end else if (r_state == S_FALL && land_req) begin
                                r_y     <= land_y;
                                r_vy    <= 8'sd0;
                                r_state <= S_GROUND;
                                r_anim  <= anim_of(1'b0, w_face_left);
                            end else begin
                                r_y     <= w_y_sum[15:0];
                                r_vy    <= w_vy_grav;
                                // Apex reached once gravity has cancelled the launch.
                                if (r_state == S_JUMP && !w_vy_grav[7])
                                    r_state <= S_FALL;
                                r_anim  <= anim_of(1'b1, w_face_left);
                            end
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign MarioX          = r_x;
    assign MarioY          = r_y;
    assign screen_offset   = r_off;
    assign Mario_Animation = r_anim;
    assign MarioAlive      = r_alive;

endmodule

// File: tb/tb_mario_motion.sv
module tb_mario_motion;

    localparam logic [3:0] A_R  = 4'd0;
    localparam logic [3:0] A_RJ = 4'd1;
    localparam logic [3:0] A_L  = 4'd2;
    localparam logic [3:0] A_LJ = 4'd3;

    logic        Clk = 1'b0;
    logic        Reset, frame_clk, kill, supported, land_req;
    logic [15:0] keycode, land_y;
    logic [15:0] MarioX, MarioY, screen_offset;
    logic [3:0]  Mario_Animation;
    logic [7:0]  MarioAlive;
    logic [15:0] X2, Y2, off2;
    logic [3:0]  anim2;
    logic [7:0]  alive2;

    mario_motion dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .kill(kill), .supported(supported), .land_req(land_req), .land_y(land_y),
        .MarioX(MarioX), .MarioY(MarioY), .screen_offset(screen_offset),
        .Mario_Animation(Mario_Animation), .MarioAlive(MarioAlive)
    );

    // Second instance starting near the scroll threshold.
    mario_motion #(.START_X(330)) dut2 (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .keycode(keycode),
        .kill(kill), .supported(supported), .land_req(land_req), .land_y(land_y),
        .MarioX(X2), .MarioY(Y2), .screen_offset(off2),
        .Mario_Animation(anim2), .MarioAlive(alive2)
    );

    always #5 Clk = ~Clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference model: mode 0 = on ground, 1 = rising, 2 = falling.
    int       m_x, m_y, m_off, m_vy, m_mode, m_alive;
    bit       m_face_l, m_dead, m_kill;
    logic [3:0] m_anim;

    task automatic model_reset();
        m_x = 64; m_y = 400; m_off = 0; m_vy = 0; m_mode = 0; m_alive = 1;
        m_face_l = 0; m_dead = 0; m_kill = 0; m_anim = A_R;
    endtask

    task automatic model_tick(input logic [15:0] k, input logic sup,
                              input logic lr, input logic [15:0] ly);
        bit l, r, j;
        int ny;
        l = (k[15:8] == 8'h04) || (k[7:0] == 8'h04);
        r = (k[15:8] == 8'h07) || (k[7:0] == 8'h07);
        j = (k[15:8] == 8'h1A) || (k[7:0] == 8'h1A);
        if (m_dead) return;
        if (m_kill) begin
            m_dead = 1; m_alive = 0;
            return;
        end
        if (l && !r) begin m_x -= 2; m_face_l = 1; end
        else if (r && !l) begin m_x += 2; m_face_l = 0; end
        if (m_x < m_off) m_x = m_off;
        if (m_x > 4000) m_x = 4000;
        if (m_x - m_off > 320) m_off = m_x - 320;
        if (m_mode == 0) begin
            if (j) begin m_vy = -12; m_mode = 1; end
            else if (m_y != 400 && !sup) begin m_vy = 0; m_mode = 2; end
        end else begin
`ifdef MARIO_VAR_JUMP_EN
            if (m_mode == 1 && !j && m_vy < -4) m_vy = -4;
`endif
            ny = m_y + m_vy;
            if (ny < 0) begin
                m_y = 0; m_vy = 0; m_mode = 2;
            end else if (m_mode == 2 && ny >= 400) begin
                m_y = 400; m_vy = 0; m_mode = 0;
            end else if (m_mode == 2 && lr) begin
                m_y = int'(ly); m_vy = 0; m_mode = 0;
            end else begin
                m_y = ny;
                m_vy = (m_vy + 1 > 8) ? 8 : m_vy + 1;
                if (m_mode == 1 && m_vy >= 0) m_mode = 2;
            end
        end
        m_anim = (m_mode == 0) ? (m_face_l ? A_L : A_R) : (m_face_l ? A_LJ : A_RJ);
    endtask

    // One frame: inputs held, frame_clk raised, outputs settled, model stepped.
    task automatic frame(input logic [15:0] k, input logic sup,
                         input logic lr, input logic [15:0] ly);
        keycode = k; supported = sup; land_req = lr; land_y = ly;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        model_tick(k, sup, lr, ly);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
    endtask

    task automatic do_reset();
        Reset = 1'b0; frame_clk = 1'b0; kill = 1'b0; keycode = 16'h0;
        supported = 1'b0; land_req = 1'b0; land_y = 16'h0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        model_reset();
    endtask

    task automatic test_reset();
        frame(16'h0007, 0, 0, 0);
        frame(16'h001A, 0, 0, 0);
        @(negedge Clk);
        #2 Reset = 1'b0;
        #1;
        n_total++; if (MarioX !== 16'd64) $display("FAIL reset_x: got %0d want 64", MarioX); else n_pass++;
        n_total++; if (MarioY !== 16'd400) $display("FAIL reset_y: got %0d want 400", MarioY); else n_pass++;
        n_total++; if (screen_offset !== 16'd0) $display("FAIL reset_off: got %0d want 0", screen_offset); else n_pass++;
        n_total++; if (Mario_Animation !== A_R) $display("FAIL reset_anim: got %0d want %0d", Mario_Animation, A_R); else n_pass++;
        n_total++; if (MarioAlive !== 8'd1) $display("FAIL reset_alive: got %0d want 1", MarioAlive); else n_pass++;
        n_total++; if (X2 !== 16'd330) $display("FAIL reset_x2: got %0d want 330", X2); else n_pass++;
        do_reset();
    endtask

    task automatic test_latency();
        do_reset();
        keycode = 16'h0007;
        @(negedge Clk);
        frame_clk = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        n_total++; if (MarioX !== 16'd64) $display("FAIL latency_early: got %0d want 64", MarioX); else n_pass++;
        @(posedge Clk);
        #1;
        n_total++; if (MarioX !== 16'd66) $display("FAIL latency_edge3: got %0d want 66", MarioX); else n_pass++;
        @(negedge Clk);
        model_tick(16'h0007, 0, 0, 0);
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame(16'h0007, 0, 0, 0);
        n_total++; if (MarioX !== 16'd68) $display("FAIL latency_one_tick: got %0d want 68", MarioX); else n_pass++;
    endtask

    task automatic test_walk_right();
        do_reset();
        for (int i = 0; i < 10; i++) frame(16'h0007, 0, 0, 0);
        n_total++; if (MarioX !== 16'd84) $display("FAIL walk_x: got %0d want 84", MarioX); else n_pass++;
        n_total++; if (screen_offset !== 16'd0) $display("FAIL walk_off: got %0d want 0", screen_offset); else n_pass++;
        n_total++; if (Mario_Animation !== A_R) $display("FAIL walk_anim: got %0d want %0d", Mario_Animation, A_R); else n_pass++;
    endtask

    task automatic test_scroll();
        do_reset();
        frame(16'h0700, 0, 0, 0);
        n_total++; if (X2 !== 16'd332) $display("FAIL scroll_x: got %0d want 332", X2); else n_pass++;
        n_total++; if (off2 !== 16'd12) $display("FAIL scroll_off: got %0d want 12", off2); else n_pass++;
        n_total++; if (MarioX !== 16'd66) $display("FAIL scroll_x1: got %0d want 66", MarioX); else n_pass++;
    endtask

    task automatic test_both_keys();
        do_reset();
        frame(16'h0004, 0, 0, 0);
        n_total++; if (MarioX !== 16'd62 || Mario_Animation !== A_L) $display("FAIL left_step: got x=%0d anim=%0d want x=62 anim=%0d", MarioX, Mario_Animation, A_L); else n_pass++;
        frame(16'h0407, 0, 0, 0);
        n_total++; if (MarioX !== 16'd62 || Mario_Animation !== A_L) $display("FAIL both_keys_a: got x=%0d anim=%0d want x=62 anim=%0d", MarioX, Mario_Animation, A_L); else n_pass++;
        frame(16'h0704, 0, 0, 0);
        n_total++; if (MarioX !== 16'd62 || Mario_Animation !== A_L) $display("FAIL both_keys_b: got x=%0d anim=%0d want x=62 anim=%0d", MarioX, Mario_Animation, A_L); else n_pass++;
        frame(16'h0007, 0, 0, 0);
        n_total++; if (MarioX !== 16'd64 || Mario_Animation !== A_R) $display("FAIL right_after_both: got x=%0d anim=%0d want x=64 anim=%0d", MarioX, Mario_Animation, A_R); else n_pass++;
    endtask

    task automatic test_jump();
        int n;
        do_reset();
        frame(16'h001A, 0, 0, 0);
        n_total++; if (MarioY !== 16'd400 || Mario_Animation !== A_RJ) $display("FAIL jump_launch: got y=%0d anim=%0d want y=400 anim=%0d", MarioY, Mario_Animation, A_RJ); else n_pass++;
        for (int i = 0; i < 12; i++) frame(16'h0000, 0, 0, 0);
        n_total++; if (MarioY !== 16'd322) $display("FAIL jump_apex: got %0d want 322", MarioY); else n_pass++;
        frame(16'h0000, 0, 0, 0);
        n_total++; if (MarioY !== 16'd322 || Mario_Animation !== A_RJ) $display("FAIL jump_fall_start: got y=%0d anim=%0d want y=322 anim=%0d", MarioY, Mario_Animation, A_RJ); else n_pass++;
        n = 0;
        while (MarioY !== 16'd400 && n < 30) begin
            frame(16'h0000, 0, 0, 0);
            n++;
            n_total++; if (MarioY !== 16'(m_y)) $display("FAIL jump_descent: got %0d want %0d", MarioY, m_y); else n_pass++;
        end
        n_total++; if (n != 14) $display("FAIL jump_descent_ticks: got %0d want 14", n); else n_pass++;
        n_total++; if (MarioY !== 16'd400 || Mario_Animation !== A_R) $display("FAIL jump_landed: got y=%0d anim=%0d want y=400 anim=%0d", MarioY, Mario_Animation, A_R); else n_pass++;
    endtask

    task automatic test_land();
        do_reset();
        frame(16'h001A, 0, 0, 0);
        for (int i = 0; i < 12; i++) frame(16'h0000, 0, 0, 0);
        frame(16'h0000, 0, 1, 16'd245);
        n_total++; if (MarioY !== 16'd245 || Mario_Animation !== A_R) $display("FAIL land_high: got y=%0d anim=%0d want y=245 anim=%0d", MarioY, Mario_Animation, A_R); else n_pass++;
        for (int i = 0; i < 5; i++) frame(16'h0000, 0, 0, 0);
        n_total++; if (MarioY !== 16'd251 || Mario_Animation !== A_RJ) $display("FAIL walk_off_fall: got y=%0d anim=%0d want y=251 anim=%0d", MarioY, Mario_Animation, A_RJ); else n_pass++;
        frame(16'h0000, 0, 1, 16'd250);
        n_total++; if (MarioY !== 16'd250 || Mario_Animation !== A_R) $display("FAIL land_req: got y=%0d anim=%0d want y=250 anim=%0d", MarioY, Mario_Animation, A_R); else n_pass++;
        frame(16'h0000, 1, 0, 0);
        n_total++; if (MarioY !== 16'd250 || Mario_Animation !== A_R) $display("FAIL land_supported: got y=%0d anim=%0d want y=250 anim=%0d", MarioY, Mario_Animation, A_R); else n_pass++;
    endtask

    task automatic test_kill();
        do_reset();
        for (int i = 0; i < 3; i++) frame(16'h0007, 0, 0, 0);
        keycode = 16'h0007;
        @(negedge Clk); kill = 1'b1;
        @(negedge Clk); kill = 1'b0;
        m_kill = 1;
        repeat (2) @(negedge Clk);
        n_total++; if (MarioAlive !== 8'd1) $display("FAIL kill_before_tick: got %0d want 1", MarioAlive); else n_pass++;
        frame(16'h0007, 0, 0, 0);
        n_total++; if (MarioAlive !== 8'd0) $display("FAIL kill_alive: got %0d want 0", MarioAlive); else n_pass++;
        n_total++; if (MarioX !== 16'd70) $display("FAIL kill_x: got %0d want 70", MarioX); else n_pass++;
        for (int i = 0; i < 5; i++) frame(16'h001A, 0, 0, 0);
        n_total++; if (MarioX !== 16'd70 || MarioY !== 16'd400) $display("FAIL dead_frozen: got x=%0d y=%0d want x=70 y=400", MarioX, MarioY); else n_pass++;
        n_total++; if (Mario_Animation !== A_R || MarioAlive !== 8'd0) $display("FAIL dead_outputs: got anim=%0d alive=%0d want anim=%0d alive=0", Mario_Animation, MarioAlive, A_R); else n_pass++;
    endtask

    task automatic test_midframe_reset();
        Reset = 1'b0; frame_clk = 1'b1; keycode = 16'h0007; kill = 1'b0;
        repeat (2) @(negedge Clk);
        Reset = 1'b1;
        model_reset();
        repeat (6) @(negedge Clk);
        n_total++; if (MarioX !== 16'd64) $display("FAIL midframe_no_tick: got %0d want 64", MarioX); else n_pass++;
        frame_clk = 1'b0;
        repeat (3) @(negedge Clk);
        frame(16'h0007, 0, 0, 0);
        n_total++; if (MarioX !== 16'd66) $display("FAIL midframe_next_tick: got %0d want 66", MarioX); else n_pass++;
    endtask

    task automatic test_clamp();
        int n;
        do_reset();
        n = 0;
        while (MarioX !== 16'd4000 && n < 2100) begin
            frame(16'h0007, 0, 0, 0);
            n++;
        end
        n_total++; if (MarioX !== 16'd4000 || screen_offset !== 16'd3680) $display("FAIL world_max: got x=%0d off=%0d want x=4000 off=3680", MarioX, screen_offset); else n_pass++;
        frame(16'h0007, 0, 0, 0);
        n_total++; if (MarioX !== 16'd4000) $display("FAIL world_max_hold: got %0d want 4000", MarioX); else n_pass++;
        for (int i = 0; i < 170; i++) frame(16'h0004, 0, 0, 0);
        n_total++; if (MarioX !== 16'd3680 || screen_offset !== 16'd3680) $display("FAIL left_clamp: got x=%0d off=%0d want x=3680 off=3680", MarioX, screen_offset); else n_pass++;
    endtask

`ifdef MARIO_VAR_JUMP_EN
    task automatic test_var_jump();
        int min_y;
        do_reset();
        frame(16'h001A, 0, 0, 0);
        frame(16'h001A, 0, 0, 0);
        frame(16'h001A, 0, 0, 0);
        min_y = int'(MarioY);
        for (int i = 0; i < 10; i++) begin
            frame(16'h0000, 0, 0, 0);
            if (int'(MarioY) < min_y) min_y = int'(MarioY);
        end
        n_total++; if (min_y != 367) $display("FAIL var_jump_apex: got %0d want 367", min_y); else n_pass++;
    endtask
`endif

    function automatic logic [7:0] rand_key();
        case ($urandom_range(0, 3))
            0: return 8'h00;
            1: return 8'h04;
            2: return 8'h07;
            default: return 8'h1A;
        endcase
    endfunction

    task automatic test_random();
        logic [15:0] k, ly;
        logic sup, lr;
        do_reset();
        for (int i = 0; i < 200; i++) begin
            k   = {rand_key(), rand_key()};
            sup = 1'($urandom_range(0, 1));
            lr  = ($urandom_range(0, 3) == 0);
            ly  = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 20)) : 16'($urandom_range(0, 399));
            frame(k, sup, lr, ly);
            n_total++; if (MarioX !== 16'(m_x)) $display("FAIL rand_x[%0d]: got %0d want %0d", i, MarioX, m_x); else n_pass++;
            n_total++; if (MarioY !== 16'(m_y)) $display("FAIL rand_y[%0d]: got %0d want %0d", i, MarioY, m_y); else n_pass++;
            n_total++; if (screen_offset !== 16'(m_off)) $display("FAIL rand_off[%0d]: got %0d want %0d", i, screen_offset, m_off); else n_pass++;
            n_total++; if (Mario_Animation !== m_anim) $display("FAIL rand_anim[%0d]: got %0d want %0d", i, Mario_Animation, m_anim); else n_pass++;
            n_total++; if (MarioAlive !== 8'(m_alive)) $display("FAIL rand_alive[%0d]: got %0d want %0d", i, MarioAlive, m_alive); else n_pass++;
        end
    endtask

    initial begin
        Reset = 1'b0; frame_clk = 1'b0; kill = 1'b0; keycode = 16'h0;
        supported = 1'b0; land_req = 1'b0; land_y = 16'h0;
        do_reset();
        test_reset();
        test_latency();
        test_walk_right();
        test_scroll();
        test_both_keys();
        test_jump();
        test_land();
        test_kill();
        test_midframe_reset();
        test_clamp();
`ifdef MARIO_VAR_JUMP_EN
        test_var_jump();
`endif
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
